// File: rtl/blockrom_stream_if.sv
// Purpose: request/response stream bundle between an address master and blockrom_stream.
// Latency: none (wires only).
// Backpressure: req_ready from the ROM side, resp_ready from the consumer side.
// Ports: req_valid/req_ready/req_addr (request), resp_valid/resp_ready/resp_data/resp_err (response).
interface blockrom_stream_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3
);
   logic                     req_valid;
   logic                     req_ready;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [DATA_WIDTH-1:0]    resp_data;
   logic                     resp_err;

   // Address generator / data consumer side
   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   // ROM side
   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/blockrom_stream.sv
// Purpose: parametrised read-only ROM with pseudo-random contents behind a valid/ready stream.
// Latency: 1 cycle accept-to-resp_valid; 2 cycles when BLOCKROM_STREAM_OUTREG_EN is defined.
// Backpressure: req_ready = !resp_valid || resp_ready; the whole pipeline freezes while a response is held.
// Ports: clk, rst (async active-high), bus (blockrom_stream_if.slave):
//   req_valid/req_ready/req_addr in, resp_valid/resp_ready/resp_data/resp_err out.
// Optional macro BLOCKROM_STREAM_OUTREG_EN adds a read register ahead of the output register.
module blockrom_stream #(
   parameter int          DATA_WIDTH    = 8,
   parameter int          ADDRESS_WIDTH = 3,
   parameter int          DEPTH         = 2**ADDRESS_WIDTH,
   parameter logic [63:0] SEED          = 64'hF4B1CA8127865242
) (
   input  logic               clk,
   input  logic               rst,
   blockrom_stream_if.slave   bus
);

   // Contents: xorshift64 sequence from SEED, each state scrambled by a
   // multiply; word i takes the low DATA_WIDTH bits of state i times the constant.
   function automatic logic [DEPTH*DATA_WIDTH-1:0] gen_rom();
      logic [63:0]                j;
      logic [63:0]                p;
      logic [DEPTH*DATA_WIDTH-1:0] r;
      j = SEED;
      r = '0;
      for (int i = 0; i < DEPTH; i++) begin
         p = j * 64'h2545F4914F6CDD1D;
         r[i*DATA_WIDTH +: DATA_WIDTH] = p[DATA_WIDTH-1:0];
         j = j ^ (j >> 12);
         j = j ^ (j << 25);
         j = j ^ (j >> 27);
      end
      return r;
   endfunction

   localparam logic [DEPTH*DATA_WIDTH-1:0] ROM_BITS = gen_rom();

   logic                  en;
   logic                  acc;
   logic                  addr_err;
   logic [DATA_WIDTH-1:0] rom_word;
   logic [DATA_WIDTH-1:0] rd_dat;

   logic                  out_vld;
   logic [DATA_WIDTH-1:0] out_dat;
   logic                  out_err;

   assign en  = !out_vld || bus.resp_ready;
   assign acc = bus.req_valid && en;

   assign addr_err = (64'(bus.req_addr) >= 64'(DEPTH));

   // Select by match rather than by index so an out-of-range address never
   // touches the array; no entry matches and the word stays zero.
   always_comb begin
      rom_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.req_addr == ADDRESS_WIDTH'(i)) begin
            rom_word = ROM_BITS[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign rd_dat = addr_err ? '0 : rom_word;

`ifdef BLOCKROM_STREAM_OUTREG_EN
   logic                  s1_vld;
   logic [DATA_WIDTH-1:0] s1_dat;
   logic                  s1_err;

   // Both stages share one enable so a held response freezes the read stage too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_dat  <= '0;
         s1_err  <= 1'b0;
         out_vld <= 1'b0;
         out_dat <= '0;
         out_err <= 1'b0;
      end else if (en) begin
         s1_vld <= acc;
         if (acc) begin
            s1_dat <= rd_dat;
            s1_err <= addr_err;
         end
         out_vld <= s1_vld;
         if (s1_vld) begin
            out_dat <= s1_dat;
            out_err <= s1_err;
         end
      end
   end
`else
   // A bubble clears only the valid; data and err keep their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld <= 1'b0;
         out_dat <= '0;
         out_err <= 1'b0;
      end else if (en) begin
         out_vld <= acc;
         if (acc) begin
            out_dat <= rd_dat;
            out_err <= addr_err;
         end
      end
   end
`endif

   assign bus.req_ready  = en;
   assign bus.resp_valid = out_vld;
   assign bus.resp_data  = out_dat;
   assign bus.resp_err   = out_err;

endmodule

// File: doc/blockrom_stream.md
Name: blockrom_stream

Overview:
- Parametrised synchronous ROM with a valid/ready request/response stream interface.
- Next generation of the fixed-latency block ROM:
  - generalised width and depth, including non-power-of-two depth;
  - seedable pseudo-random contents;
  - backpressure support;
  - out-of-range flagging.
- Sits between an address-generating master and a data consumer. Either side may stall.

Parameters:
- DATA_WIDTH, 8, width of each ROM word (1..64).
- ADDRESS_WIDTH, 3, width of req_addr.
- DEPTH, 2**ADDRESS_WIDTH, number of valid words (1..2**ADDRESS_WIDTH).
- SEED, 64'hF4B1CA8127865242, 64-bit initial state of the content generator (must be nonzero).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request address is valid.
- req_ready  output  1  block accepts a request this cycle.
- req_addr  input  ADDRESS_WIDTH  word address.
- resp_valid  output  1  response data is valid.
- resp_ready  input  1  consumer accepts the response this cycle.
- resp_data  output  DATA_WIDTH  ROM word.
- resp_err  output  1  the address was >= DEPTH.

Behaviour:
- Contents are fixed at elaboration by an initial loop, using 64-bit unsigned arithmetic with j = SEED. For i = 0..DEPTH-1:
  - mem[i] = low DATA_WIDTH bits of (j * 64'h2545F4914F6CDD1D);
  - then j ^= j>>12; j ^= j<<25; j ^= j>>27.
- The ROM is never written after initialisation.
- Reset values (asynchronous): resp_valid=0, resp_data=0, resp_err=0, all internal stage valids 0.
- The ROM array itself is unaffected by reset.
- Pipeline enable: en = !resp_valid || resp_ready.
  - req_ready = en. It is combinational from resp_valid and resp_ready only, never from req_valid.
- Accept: a request is accepted on a rising edge when req_valid && req_ready.
- Base latency = 1:
  - the accepted address produces resp_valid=1 on the next edge;
  - resp_data = mem[addr];
  - resp_err = (addr >= DEPTH).
- Out of range: if addr >= DEPTH, resp_data=0 and resp_err=1. The memory array is not indexed.
- Stall: while resp_valid && !resp_ready:
  - resp_data and resp_err hold stable;
  - req_ready=0;
  - no new request is accepted and no memory read occurs.
- Bubble: if en=1 and req_valid=0, resp_valid falls to 0 on the next edge. resp_data holds its last value (not cleared).
- Simultaneous events: if resp_ready=1 and req_valid=1 with resp_valid=1, the response is consumed and the new one is loaded in the same edge. Sustained throughput is one word per cycle.
- Ordering: responses return strictly in request order. There are no drops or duplicates.
- Reset mid-operation: all in-flight and held responses are discarded. The first request after reset release behaves as from an idle state.
- req_addr is sampled only on accept. It may change freely otherwise.

Optional Feature:
- Macro: BLOCKROM_STREAM_OUTREG_EN.
- Defined:
  - adds a second register stage (mem read register -> output register). Latency = 2.
  - stage 1 and stage 2 both advance only when en = !resp_valid || resp_ready. The whole pipeline stalls together.
  - req_ready = en. Throughput remains one word per cycle.
  - reset clears both stage valids.
  - a bubble in stage 1 propagates to resp_valid one cycle later.
- Undefined: the single-stage behaviour above with latency 1.

Test Plan:
- Default params, reset, req_addr=0, req_valid=1 for one cycle, resp_ready=1 -> resp_valid=1 one cycle after accept (two with OUTREG), resp_data=8'h7A, resp_err=0.
- Stream addresses 0..7 back-to-back, resp_ready=1 -> 8 consecutive responses, no bubbles, data matching a 64-bit xorshift reference model of SEED, req_ready constantly 1.
- Hold resp_ready=0 for 5 cycles with a response pending -> req_ready=0, resp_data/resp_err stable, no accepts. On release, the next word follows the held word in order.
- DEPTH=5, ADDRESS_WIDTH=3, request addr 4 then 5 then 7 -> addr 4 gives model data with err=0; addrs 5 and 7 give resp_data=0, resp_err=1.
- Assert rst for 1 cycle while resp_valid=1 and stalled -> resp_valid=0 and resp_data=0 immediately (asynchronously). A request for addr 2 after release returns mem[2] with normal latency.
- Random req_valid/resp_ready toggling, 1000 cycles, both macro settings -> scoreboard shows every accepted address answered exactly once, in order, with correct data and err.
